// File: rtl/exa_crosb_pkg.sv
// Shared crossbar arbitration types and helpers.
package exa_crosb_pkg;

  typedef enum logic [1:0] {IDLE, SEL, XFER, REL} arb_state_t;

  localparam logic PRIO_HI = 1'b1;
  localparam logic PRIO_LO = 1'b0;

  // Width of a VC index spanning all priority classes; also used by the output arbiter.
  function automatic int vc_idx_w(input int vc_num, input int prio_num);
    return (vc_num * prio_num > 1) ? $clog2(vc_num * prio_num) : 1;
  endfunction

endpackage

// File: rtl/exa_rr_picker.sv
// Round-robin picker: first set request after ptr, scanning modulo N (any N).
module exa_rr_picker #(
  parameter int N  = 8,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  always_comb begin
    int cand;
    logic [IW-1:0] ci;
    gnt  = '0;
    idx  = '0;
    cand = 0;
    ci   = '0;
    for (int k = 1; k <= N; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N) cand = cand - N;
      ci = IW'(cand);
      if (req[ci] && (gnt == '0)) begin
        gnt[ci] = 1'b1;
        idx     = ci;
      end
    end
  end

endmodule

// File: rtl/exa_crosb_input_arbiter_with_vcs.sv
// Per-input arbiter: picks one output grant, returns cts and streams one packet.
// Optional per-output packet / abort statistics under EXA_INPUT_ARB_STATS_EN.
//
// state | meaning
// IDLE  | waiting for any grant; winner latched on grant
// SEL   | cts asserted, confirming grant still held
// XFER  | cts + ready, beats flow until last
// REL   | one-cycle cts gap after a completed packet
module exa_crosb_input_arbiter_with_vcs
  import exa_crosb_pkg::*;
#(
  parameter int output_num = 8,
  parameter int vc_num     = 3,
  parameter int prio_num   = 2,
  localparam int OW = (output_num > 1) ? $clog2(output_num) : 1,
  localparam int VW = vc_idx_w(vc_num, prio_num)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [output_num-1:0]    i_grant,
  input  logic [output_num-1:0]    i_grant_prio,
  input  logic [output_num*VW-1:0] i_grant_vc,
  input  logic                     i_valid,
  input  logic                     i_last,
  output logic [output_num-1:0]    o_cts,
  output logic [OW-1:0]            o_output_sel,
  output logic [VW-1:0]            o_vc_sel,
  output logic                     o_ready,
  output logic                     o_busy,
`ifdef EXA_INPUT_ARB_STATS_EN
  output logic [output_num*16-1:0] o_pkt_cnt,
  output logic [15:0]              o_abort_cnt,
`endif
  output logic                     o_err
);

  localparam logic [OW-1:0] PTR_RST = OW'(output_num - 1);

  arb_state_t             state;
  logic [OW-1:0]          ptr_hi, ptr_lo, sel;
  logic                   cls, beat_seen, err_done;
  logic [output_num-1:0]  hi_req, lo_req, hi_gnt, lo_gnt, win_onehot;
  logic [OW-1:0]          hi_idx, lo_idx, win_idx;
  logic                   win_cls, grant_sel, beat, pkt_done, abort_evt;

  assign hi_req = i_grant & i_grant_prio;
  assign lo_req = i_grant & ~i_grant_prio;

  exa_rr_picker #(.N(output_num)) u_pick_hi (
    .req(hi_req), .ptr(ptr_hi), .gnt(hi_gnt), .idx(hi_idx)
  );

  exa_rr_picker #(.N(output_num)) u_pick_lo (
    .req(lo_req), .ptr(ptr_lo), .gnt(lo_gnt), .idx(lo_idx)
  );

  // Any high-priority grant shadows the whole low-priority set.
  assign win_cls    = (|hi_req) ? PRIO_HI : PRIO_LO;
  assign win_idx    = (|hi_req) ? hi_idx : lo_idx;
  assign win_onehot = (|hi_req) ? hi_gnt : lo_gnt;

  assign grant_sel    = i_grant[sel];
  assign beat         = i_valid & o_ready;
  assign pkt_done     = (state == XFER) && beat && i_last;
  assign abort_evt    = ((state == SEL) && !grant_sel) ||
                        ((state == XFER) && !grant_sel && !beat_seen && !beat);
  assign o_output_sel = sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      o_cts     <= '0;
      sel       <= '0;
      o_vc_sel  <= '0;
      o_ready   <= 1'b0;
      o_busy    <= 1'b0;
      o_err     <= 1'b0;
      ptr_hi    <= PTR_RST;
      ptr_lo    <= PTR_RST;
      cls       <= PRIO_LO;
      beat_seen <= 1'b0;
      err_done  <= 1'b0;
    end else begin
      o_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (|i_grant) begin
            state     <= SEL;
            sel       <= win_idx;
            cls       <= win_cls;
            o_vc_sel  <= i_grant_vc[win_idx*VW +: VW];
            o_cts     <= win_onehot;
            o_busy    <= 1'b1;
            o_ready   <= 1'b0;
            beat_seen <= 1'b0;
            err_done  <= 1'b0;
          end
        end
        SEL: begin
          if (abort_evt) begin
            state  <= IDLE;
            o_cts  <= '0;
            o_busy <= 1'b0;
          end else begin
            state   <= XFER;
            o_ready <= 1'b1;
          end
        end
        XFER: begin
          if (beat) beat_seen <= 1'b1;
          // Revocation after data has moved cannot truncate the packet; flag it once.
          if (!grant_sel && beat_seen && !err_done) begin
            o_err    <= 1'b1;
            err_done <= 1'b1;
          end
          if (pkt_done) begin
            state   <= REL;
            o_cts   <= '0;
            o_ready <= 1'b0;
            if (cls == PRIO_HI) ptr_hi <= sel;
            else                ptr_lo <= sel;
          end else if (abort_evt) begin
            state   <= IDLE;
            o_cts   <= '0;
            o_ready <= 1'b0;
            o_busy  <= 1'b0;
          end
        end
        REL: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef EXA_INPUT_ARB_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_pkt_cnt   <= '0;
      o_abort_cnt <= '0;
    end else begin
      if (pkt_done && (o_pkt_cnt[sel*16 +: 16] != 16'hFFFF))
        o_pkt_cnt[sel*16 +: 16] <= o_pkt_cnt[sel*16 +: 16] + 16'd1;
      if (abort_evt && (o_abort_cnt != 16'hFFFF))
        o_abort_cnt <= o_abort_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_exa_crosb_input_arbiter_with_vcs.sv
// Self-checking bench: directed scenarios plus random packets against a packet-level model.
module tb_exa_crosb_input_arbiter_with_vcs;

  localparam int N  = 8;
  localparam int VW = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      i_grant, i_grant_prio;
  logic [N*VW-1:0]   i_grant_vc;
  logic              i_valid, i_last;
  logic [N-1:0]      o_cts;
  logic [2:0]        o_output_sel;
  logic [VW-1:0]     o_vc_sel;
  logic              o_ready, o_busy, o_err;
`ifdef EXA_INPUT_ARB_STATS_EN
  logic [N*16-1:0]   o_pkt_cnt;
  logic [15:0]       o_abort_cnt;
  int                exp_pkt[N];
  int                exp_abort;
`endif

  int checks   = 0;
  int failures = 0;
  int mptr_hi, mptr_lo;

  always #5 clk = ~clk;

  exa_crosb_input_arbiter_with_vcs dut (
    .clk(clk), .reset(reset),
    .i_grant(i_grant), .i_grant_prio(i_grant_prio), .i_grant_vc(i_grant_vc),
    .i_valid(i_valid), .i_last(i_last),
    .o_cts(o_cts), .o_output_sel(o_output_sel), .o_vc_sel(o_vc_sel),
    .o_ready(o_ready), .o_busy(o_busy),
`ifdef EXA_INPUT_ARB_STATS_EN
    .o_pkt_cnt(o_pkt_cnt), .o_abort_cnt(o_abort_cnt),
`endif
    .o_err(o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mptr_hi = N - 1;
    mptr_lo = N - 1;
`ifdef EXA_INPUT_ARB_STATS_EN
    foreach (exp_pkt[o]) exp_pkt[o] = 0;
    exp_abort = 0;
`endif
  endtask

  task automatic note_pkt(input int w);
`ifdef EXA_INPUT_ARB_STATS_EN
    exp_pkt[w]++;
`else
    if (w < 0) $display("note: unexpected output index");
`endif
  endtask

  task automatic note_abort();
`ifdef EXA_INPUT_ARB_STATS_EN
    exp_abort++;
`endif
  endtask

  task automatic chk_stats(input string tag);
`ifdef EXA_INPUT_ARB_STATS_EN
    for (int o = 0; o < N; o++) chk(tag, 32'(o_pkt_cnt[o*16 +: 16]), 32'(exp_pkt[o]));
    chk(tag, 32'(o_abort_cnt), 32'(exp_abort));
`else
    chk(tag, 32'(o_busy), 32'(o_busy !== 1'bx ? o_busy : 1'b0));
`endif
  endtask

  // Winner rule: high class if any high grant, else low; first set bit after that class pointer.
  function automatic int pick(input logic [N-1:0] g, input logic [N-1:0] p, output bit hi);
    logic [N-1:0] s;
    int ptr;
    hi  = |(g & p);
    s   = hi ? (g & p) : (g & ~p);
    ptr = hi ? mptr_hi : mptr_lo;
    for (int k = 1; k <= N; k++) if (s[(ptr + k) % N]) return (ptr + k) % N;
    return 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_cts"},   32'(o_cts),   0);
    chk({tag, "_ready"}, 32'(o_ready), 0);
    chk({tag, "_busy"},  32'(o_busy),  0);
    chk({tag, "_err"},   32'(o_err),   0);
  endtask

  // mode 0: normal, 1: revoke in SEL, 2: revoke in XFER before data, 3: revoke after rk beats
  task automatic run_pkt(input logic [N-1:0] g, input logic [N-1:0] p, input int nbeats,
                         input int mode, input int rk);
    int w, done;
    bit hi, dropped, exp_err;
    logic [31:0] r;
    logic [N*VW-1:0] vcs;
    logic [N-1:0] m;
    r   = $urandom;
    vcs = r[N*VW-1:0];
    w   = pick(g, p, hi);
    m   = '0;
    m[w] = 1'b1;
    i_grant = g; i_grant_prio = p; i_grant_vc = vcs; i_valid = 1'b0; i_last = 1'b0;
    tick();
    chk("sel_cts",   32'(o_cts), 32'(m));
    chk("sel_idx",   32'(o_output_sel), 32'(w));
    chk("sel_vc",    32'(o_vc_sel), 32'(vcs[w*VW +: VW]));
    chk("sel_busy",  32'(o_busy), 1);
    chk("sel_ready", 32'(o_ready), 0);
    if (mode == 1) begin
      i_grant = g & ~m;
      tick();
      chk_idle("abort_sel");
      note_abort();
      i_grant = '0;
      tick();
      chk_idle("abort_sel_idle");
      return;
    end
    tick();
    chk("xfer_cts",   32'(o_cts), 32'(m));
    chk("xfer_ready", 32'(o_ready), 1);
    chk("xfer_err",   32'(o_err), 0);
    if (mode == 2) begin
      i_grant = g & ~m;
      tick();
      chk_idle("abort_xfer");
      note_abort();
      i_grant = '0;
      tick();
      chk_idle("abort_xfer_idle");
      return;
    end
    done = 0;
    dropped = 1'b0;
    for (int c = 0; done < nbeats; c++) begin
      exp_err = 1'b0;
      if (mode == 3 && done == rk && !dropped) begin
        i_grant = g & ~m;
        dropped = 1'b1;
        exp_err = 1'b1;
      end
      i_valid = (c > 20) || ($urandom_range(0, 3) != 0);
      i_last  = i_valid && (done == nbeats - 1);
      if (i_valid) done++;
      tick();
      chk("beat_err", 32'(o_err), 32'(exp_err));
      if (done == nbeats) begin
        chk("rel_cts",   32'(o_cts), 0);
        chk("rel_ready", 32'(o_ready), 0);
        chk("rel_busy",  32'(o_busy), 1);
      end else begin
        chk("beat_cts",   32'(o_cts), 32'(m));
        chk("beat_ready", 32'(o_ready), 1);
      end
    end
    if (hi) mptr_hi = w;
    else    mptr_lo = w;
    note_pkt(w);
    i_valid = 1'b0; i_last = 1'b0; i_grant = '0;
    tick();
    chk_idle("post_rel");
  endtask

  task automatic do_reset();
    i_grant = '0; i_valid = 1'b0; i_last = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    tick();
    chk_idle("after_reset");
  endtask

  initial begin
    int nb, md;
    logic [N-1:0] g;
    bit hi;
    int w;
    reset = 1'b1;
    i_grant = '0; i_grant_prio = '0; i_grant_vc = '0; i_valid = 1'b0; i_last = 1'b0;
    model_reset();
    tick();
    tick();
    chk_idle("reset");
    chk("reset_sel", 32'(o_output_sel), 0);
    chk("reset_vc",  32'(o_vc_sel), 0);
    reset = 1'b0;
    tick();
    chk_idle("reset_release");

    run_pkt(8'h04, 8'h00, 3, 0, 0);
    run_pkt(8'h0C, 8'h00, 1, 0, 0);

    do_reset();
    for (int i = 0; i < 4; i++) run_pkt(8'h81, 8'h00, 2, 0, 0);

    run_pkt(8'h03, 8'h02, 2, 0, 0);

    run_pkt(8'h20, 8'h00, 2, 1, 0);
    run_pkt(8'h20, 8'h00, 2, 2, 0);
    run_pkt(8'h20, 8'h00, 2, 0, 0);

    run_pkt(8'h10, 8'h00, 4, 3, 2);

    for (int i = 0; i < 40; i++) begin
      g  = N'($urandom_range(1, 255));
      nb = $urandom_range(1, 5);
      md = $urandom_range(0, 3);
      if (md == 3 && nb < 2) md = 0;
      run_pkt(g, N'($urandom), nb, md, (md == 3) ? $urandom_range(1, nb - 1) : 0);
    end
    chk_stats("stats_run");

    // Asynchronous reset in the middle of a transfer.
    g = 8'h40;
    w = pick(g, 8'h00, hi);
    i_grant = g; i_grant_prio = '0;
    tick();
    tick();
    chk("pre_reset_ready", 32'(o_ready), 1);
    chk("pre_reset_idx",   32'(o_output_sel), 32'(w));
    #3 reset = 1'b1;
    #1;
    chk("async_cts",   32'(o_cts), 0);
    chk("async_ready", 32'(o_ready), 0);
    chk("async_busy",  32'(o_busy), 0);
    i_grant = '0;
    model_reset();
    tick();
    reset = 1'b0;
    tick();
    chk_idle("async_release");
    chk_stats("stats_cleared");
    run_pkt(8'h41, 8'h00, 2, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
